// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronises and de-glitches the pins, deframes
// 11-bit frames and keeps the last two good bytes as {previous, newest}.
module ps2_scancode_rx #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic        oflag,
    output logic        frame_err
);

    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    logic [1:0]     clk_sync_q;
    logic [1:0]     data_sync_q;
    logic [FCW-1:0] filt_cnt_q;
    logic           clk_filt_q;
    logic           clk_filt_prev_q;
    logic           fall_c;
    logic           data_c;

    state_e         state_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shreg_q;
    logic           par_ok_q;
    logic [TW-1:0]  tmo_q;
    logic [15:0]    keycode_q;
    logic           oflag_q;
    logic           frame_err_q;

    // Synchronisers and ps2_clk glitch filter; idle-high bus after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q      <= 2'b11;
            data_sync_q     <= 2'b11;
            filt_cnt_q      <= '0;
            clk_filt_q      <= 1'b1;
            clk_filt_prev_q <= 1'b1;
        end else begin
            clk_sync_q      <= {clk_sync_q[0], ps2_clk};
            data_sync_q     <= {data_sync_q[0], ps2_data};
            clk_filt_prev_q <= clk_filt_q;
            if (clk_sync_q[1] == clk_filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                clk_filt_q <= ~clk_filt_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FCW'(1);
            end
        end
    end

    assign fall_c = clk_filt_prev_q & ~clk_filt_q;
    assign data_c = data_sync_q[1];

    // Frame deserialiser; timeout takes priority over a coincident sample event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            par_ok_q    <= 1'b0;
            tmo_q       <= '0;
            keycode_q   <= '0;
            oflag_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            oflag_q     <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES)) begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
                tmo_q       <= '0;
            end else if (fall_c) begin
                tmo_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (!data_c) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shreg_q   <= {data_c, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_ok_q <= ^{shreg_q, data_c};
                        state_q  <= STOP;
                    end
                    STOP: begin
                        if (data_c && par_ok_q) begin
                            keycode_q <= {keycode_q[7:0], shreg_q};
                            oflag_q   <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                tmo_q <= tmo_q + TW'(1);
            end else begin
                tmo_q <= '0;
            end
        end
    end

    assign keycode   = keycode_q;
    assign oflag     = oflag_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomised bench for ps2_scancode_rx: frames built from the PS/2 framing rules,
// results compared with a byte-level model of the keycode history and pulse counts.
module tb_ps2_scancode_rx;

    localparam int unsigned FILTER_LEN = 4;
    localparam int unsigned TIMEOUT    = 600;
    localparam int unsigned H          = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] keycode;
    logic        oflag;
    logic        frame_err;

    int n_chk = 0;
    int n_err = 0;
    int of_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    logic [15:0] exp_kc = 16'h0000;

    ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .oflag(oflag), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse so a stretched pulse shows up as extra counts
    always @(negedge clk) begin
        if (!rst) begin
            if (oflag) of_cnt++;
            if (frame_err) fe_cnt++;
            if (oflag && frame_err) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind: 0 good, 1 parity flipped, 2 stop bit 0, 3 good with a short ps2_clk glitch
    task automatic send_frame(input logic [7:0] b, input int kind, input int nbits);
        logic [10:0] f;
        logic par;
        par = ~(^b);
        if (kind == 1) par = ~par;
        f = {(kind == 2) ? 1'b0 : 1'b1, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2_data = f[i];
            repeat (H) @(negedge clk);
            if (kind == 3 && i == 4) begin
                ps2_clk = 1'b0;
                repeat (FILTER_LEN - 1) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (H) @(negedge clk);
            end
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk) ps2_data = 1'b1;
        repeat (3 * H) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input int kind);
        int of0, fe0;
        bit good;
        of0 = of_cnt;
        fe0 = fe_cnt;
        good = (kind == 0 || kind == 3);
        send_frame(b, kind, 11);
        if (good) exp_kc = {exp_kc[7:0], b};
        check({tag, ".keycode"}, 32'(keycode), 32'(exp_kc));
        check({tag, ".oflag"}, 32'(of_cnt - of0), good ? 32'd1 : 32'd0);
        check({tag, ".frame_err"}, 32'(fe_cnt - fe0), good ? 32'd0 : 32'd1);
    endtask

    initial begin
        int of0, fe0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset.keycode", 32'(keycode), 32'h0);
        check("reset.oflag", 32'(oflag), 32'h0);
        check("reset.frame_err", 32'(frame_err), 32'h0);

        run_frame("t1_29", 8'h29, 0);
        run_frame("t2_F0", 8'hF0, 0);
        run_frame("t2_29", 8'h29, 0);
        check("t2.keycode_F029", 32'(keycode), 32'hF029);
        run_frame("t2_23", 8'h23, 0);
        check("t2.keycode_2923", 32'(keycode), 32'h2923);
        run_frame("t3_bad_par", 8'h1C, 1);
        run_frame("t3_good", 8'h1C, 0);
        run_frame("t4_glitch", 8'h23, 3);

        // Truncated frame: start + 5 data bits, then silence past the timeout
        of0 = of_cnt;
        fe0 = fe_cnt;
        send_frame(8'h5A, 0, 6);
        repeat (TIMEOUT + 200) @(negedge clk);
        check("t5.frame_err", 32'(fe_cnt - fe0), 32'd1);
        check("t5.oflag", 32'(of_cnt - of0), 32'd0);
        check("t5.keycode", 32'(keycode), 32'(exp_kc));
        run_frame("t5_after", 8'h29, 0);

        // Reset mid-frame after 3 data bits
        of0 = of_cnt;
        fe0 = fe_cnt;
        send_frame(8'h77, 0, 4);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        exp_kc = 16'h0000;
        repeat (TIMEOUT + 200) @(negedge clk);
        check("t6.keycode", 32'(keycode), 32'h0);
        check("t6.pulses", 32'((of_cnt - of0) + (fe_cnt - fe0)), 32'd0);
        run_frame("t6_after", 8'h23, 0);
        check("t6.keycode_0023", 32'(keycode), 32'h0023);

        for (int i = 0; i < 16; i++) begin
            run_frame($sformatf("rnd%0d", i), 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end

        check("never_both", 32'(both_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
